// File: rtl/ddr3_pack_fifo_if.sv
// ---------------------------------------------------------------------------
// ddr3_pack_fifo_if
// Groups the write side, read side and status signals of ddr3_pack_fifo.
//   wr_en / wr_data / wr_ready     : narrow write handshake
//   rd_data / rd_valid / rd_ready  : wide first-word-fall-through read
//   wcount                         : wide entries currently stored
//   pack_cnt                       : narrow words waiting in the packer
//   overflow                       : sticky dropped-write flag
//   init_ok                        : block is out of its flush period
// The master modport belongs to the client, the slave modport to the buffer.
// ---------------------------------------------------------------------------
interface ddr3_pack_fifo_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 128,
   parameter int DEPTH = 512
);
   localparam int RATIO = OUT_W / IN_W;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int PW    = $clog2(RATIO) + 1;

   logic             wr_en;
   logic [IN_W-1:0]  wr_data;
   logic             wr_ready;
   logic [OUT_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [CW-1:0]    wcount;
   logic [PW-1:0]    pack_cnt;
   logic             overflow;
   logic             init_ok;

   modport master (
      output wr_en, wr_data, rd_ready,
      input  wr_ready, rd_data, rd_valid, wcount, pack_cnt, overflow, init_ok
   );

   modport slave (
      input  wr_en, wr_data, rd_ready,
      output wr_ready, rd_data, rd_valid, wcount, pack_cnt, overflow, init_ok
   );
endinterface

// File: rtl/ddr3_pack_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_pack_fifo
// Width-converting frame buffer in front of the DDR3 user write port.
// RATIO = OUT_W/IN_W narrow words are packed LSB-first into one wide word,
// which is stored in a DEPTH-entry FIFO read out first-word-fall-through.
// A rising edge on load (and reset) flushes everything and keeps the block
// busy for FLUSH_CYCLES cycles.
//
// Ports:
//   clk_100        : sole clock, rising edge
//   rst            : asynchronous active-high reset
//   load           : frame-load level, rising edge triggers a flush
//   flush_partial  : (PACK_PAD_EN only) commit a partially filled word
//   bus            : ddr3_pack_fifo_if.slave, write/read handshakes + status
//
// Optional feature macro: PACK_PAD_EN. When defined, flush_partial exists and
// a partial word is committed with PAD_VALUE in its unfilled lanes.
// ---------------------------------------------------------------------------
module ddr3_pack_fifo #(
   parameter int              IN_W         = 16,
   parameter int              OUT_W        = 128,
   parameter int              DEPTH        = 512,
   parameter int              FLUSH_CYCLES = 16,
   parameter logic [IN_W-1:0] PAD_VALUE    = '0
) (
   input logic clk_100,
   input logic rst,
   input logic load,
`ifdef PACK_PAD_EN
   input logic flush_partial,
`endif
   ddr3_pack_fifo_if.slave bus
);

   localparam int RATIO = OUT_W / IN_W;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int PW    = $clog2(RATIO) + 1;
   localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [PW-1:0]   LAST_LANE = PW'(RATIO - 1);
   localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
   localparam logic [FC_W-1:0] RELOAD    = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic {FLUSH, RUN} state_t;

   state_t           state_q, state_d;
   logic [FC_W-1:0]  flushCnt_q, flushCnt_d;
   logic             load_q;
   logic             loadEdge;
   logic             running;
   logic             clearAll;

   logic [OUT_W-1:0] packBuf_q, packBuf_d;
   logic [PW-1:0]    packCnt_q, packCnt_d;
   logic [OUT_W-1:0] fullWord;
   logic [OUT_W-1:0] commitData;
   logic             wrReady;
   logic             accept;
   logic             drop;
   logic             fullCommit;
   logic             padCommit;
   logic             padBlock;
   logic             commit;

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    wcount_q, wcount_d;
   logic [CW-1:0]    ramCnt;
   logic             outValid_q, outValid_d;
   logic [OUT_W-1:0] outData_q;
   logic             outLoad;
   logic             rdValid;
   logic             pop;
   logic             overflow_q, overflow_d;

   // Keep one registered copy of load so a frame start is seen exactly once,
   // on the cycle the level first goes high.
   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         load_q <= 1'b0;
      end else begin
         load_q <= load;
      end
   end

   assign loadEdge = load & ~load_q;

   // Flush/run state register together with the busy countdown.
   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         state_q    <= FLUSH;
         flushCnt_q <= RELOAD;
      end else begin
         state_q    <= state_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   // Next-state logic: the countdown runs only while flushing, and any new
   // load edge restarts it, whether we are running or already flushing.
   always_comb begin
      state_d    = state_q;
      flushCnt_d = flushCnt_q;
      case (state_q)
         FLUSH: begin
            if (loadEdge) begin
               flushCnt_d = RELOAD;
            end else if (flushCnt_q == '0) begin
               state_d = RUN;
            end else begin
               flushCnt_d = flushCnt_q - 1'b1;
            end
         end
         RUN: begin
            if (loadEdge) begin
               state_d    = FLUSH;
               flushCnt_d = RELOAD;
            end
         end
         default: begin
            state_d    = FLUSH;
            flushCnt_d = RELOAD;
         end
      endcase
   end

   // A load edge seen in RUN wipes the contents on that same edge, so the
   // clear condition covers the edge as well as the whole flush period.
   assign running  = (state_q == RUN);
   assign clearAll = ~running | loadEdge;

   // Writes are refused only when the next accept would need a free slot
   // that is not there; reads are never allowed to influence this.
   assign wrReady    = running & ~padBlock & ~((packCnt_q == LAST_LANE) && (wcount_q == FULL_CNT));
   assign accept     = bus.wr_en & wrReady;
   assign drop       = running & bus.wr_en & ~wrReady;
   assign fullCommit = accept & (packCnt_q == LAST_LANE);

   // Packer: each accepted word goes into the next lane up; the completed
   // word is built from the stored lanes plus the word arriving right now.
   always_comb begin
      packBuf_d = packBuf_q;
      fullWord  = packBuf_q;
      fullWord[(RATIO-1)*IN_W +: IN_W] = bus.wr_data;
      if (accept) begin
         packBuf_d[int'(packCnt_q)*IN_W +: IN_W] = bus.wr_data;
      end
   end

`ifdef PACK_PAD_EN
   logic             padPend_q, padPend_d;
   logic [OUT_W-1:0] padWord;

   // Partial word: lanes already written keep their data, the rest carry the
   // pad value.
   always_comb begin
      padWord = packBuf_q;
      for (int i = 0; i < RATIO; i++) begin
         if (i >= int'(packCnt_q)) begin
            padWord[i*IN_W +: IN_W] = PAD_VALUE;
         end
      end
   end

   // A pulse is latched and served on a later cycle once a slot is free.
   // Latching looks at the packer count after this cycle's accept, so a
   // pulse coinciding with a write covers that write too, and a pulse on an
   // empty packer is ignored. Writes stay blocked while a request waits.
   assign padCommit = padPend_q & running & (wcount_q != FULL_CNT);

   always_comb begin
      padPend_d = padPend_q;
      if (clearAll) begin
         padPend_d = 1'b0;
      end else if (padCommit) begin
         padPend_d = 1'b0;
      end else if (flush_partial && (packCnt_d != '0)) begin
         padPend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         padPend_q <= 1'b0;
      end else begin
         padPend_q <= padPend_d;
      end
   end

   assign padBlock   = padPend_q;
   assign commit     = fullCommit | padCommit;
   assign commitData = padCommit ? padWord : fullWord;
`else
   assign padCommit  = 1'b0;
   assign padBlock   = 1'b0;
   assign commit     = fullCommit;
   assign commitData = fullWord;
`endif

   // Read side: the output register holds the head entry, and wcount counts
   // it together with everything still in the RAM. The register refills from
   // the RAM whenever it is empty or being popped and the RAM holds data, so
   // a word written at one edge becomes visible after the next edge.
   assign rdValid = running & outValid_q;
   assign pop     = rdValid & bus.rd_ready;
   assign ramCnt  = wcount_q - CW'(outValid_q);
   assign outLoad = (ramCnt != '0) && (!outValid_q || pop);

   // Occupancy, pointer and flag bookkeeping; everything collapses to zero
   // while flushing.
   always_comb begin
      packCnt_d  = packCnt_q;
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      wcount_d   = wcount_q + CW'(commit) - CW'(pop);
      outValid_d = outValid_q;
      overflow_d = overflow_q | drop;
      if (padCommit) begin
         packCnt_d = '0;
      end else if (accept) begin
         packCnt_d = fullCommit ? '0 : packCnt_q + 1'b1;
      end
      if (commit) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (outLoad) begin
         rdPtr_d    = rdPtr_q + 1'b1;
         outValid_d = 1'b1;
      end else if (pop) begin
         outValid_d = 1'b0;
      end
      if (clearAll) begin
         packCnt_d  = '0;
         wrPtr_d    = '0;
         rdPtr_d    = '0;
         wcount_d   = '0;
         outValid_d = 1'b0;
         overflow_d = 1'b0;
      end
   end

   // Control and packer registers. Unused packer lanes start out holding the
   // pad value.
   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         packBuf_q  <= {RATIO{PAD_VALUE}};
         packCnt_q  <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         wcount_q   <= '0;
         outValid_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         packBuf_q  <= clearAll ? {RATIO{PAD_VALUE}} : packBuf_d;
         packCnt_q  <= packCnt_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         wcount_q   <= wcount_d;
         outValid_q <= outValid_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage write port, kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk_100) begin
      if (commit) begin
         mem[wrPtr_q] <= commitData;
      end
   end

   // Registered read into the head-of-queue output register.
   always_ff @(posedge clk_100 or posedge rst) begin
      if (rst) begin
         outData_q <= '0;
      end else if (outLoad) begin
         outData_q <= mem[rdPtr_q];
      end
   end

   assign bus.wr_ready = wrReady;
   assign bus.rd_data  = outData_q;
   assign bus.rd_valid = rdValid;
   assign bus.wcount   = wcount_q;
   assign bus.pack_cnt = packCnt_q;
   assign bus.overflow = overflow_q;
   assign bus.init_ok  = running;

endmodule

// File: tb/tb_ddr3_pack_fifo.sv
// ---------------------------------------------------------------------------
// tb_ddr3_pack_fifo
// Self-checking bench for ddr3_pack_fifo with IN_W=16, OUT_W=128, DEPTH=4,
// FLUSH_CYCLES=16, PAD_VALUE=16'hFFFF. Expected wide words are assembled by
// the bench as writes are accepted and queued; each pop is compared against
// the head of that queue.
// ---------------------------------------------------------------------------
module tb_ddr3_pack_fifo;

   localparam int IN_W  = 16;
   localparam int OUT_W = 128;
   localparam int DEPTH = 4;
   localparam int RATIO = OUT_W / IN_W;

   logic clk_100;
   logic rst;
   logic load;
`ifdef PACK_PAD_EN
   logic flush_partial;
`endif

   ddr3_pack_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

   ddr3_pack_fifo #(
      .IN_W(IN_W),
      .OUT_W(OUT_W),
      .DEPTH(DEPTH),
      .FLUSH_CYCLES(16),
      .PAD_VALUE(16'hFFFF)
   ) dut (
      .clk_100(clk_100),
      .rst(rst),
      .load(load),
`ifdef PACK_PAD_EN
      .flush_partial(flush_partial),
`endif
      .bus(bus)
   );

   int             assertCount = 0;
   int             failCount   = 0;
   int             mPack       = 0;
   int             mCount      = 0;
   logic           mOvf        = 1'b0;
   logic [127:0]   mWord       = '0;
   logic [127:0]   sb[$];

   // 100 MHz clock.
   initial begin
      clk_100 = 1'b0;
      forever #5 clk_100 = ~clk_100;
   end

   // Safety net in case the run wedges.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // One clock of stimulus, entered and left at posedge+1. The bench decides
   // acceptance from its own occupancy model, builds expected words, and
   // checks popped data against the scoreboard head.
   task automatic applyStimulus(input logic we, input logic [15:0] d, input logic rr);
      logic expReady;
      logic acc;
      logic popNow;
      bus.wr_en    = we;
      bus.wr_data  = d;
      bus.rd_ready = rr;
      @(negedge clk_100);
      expReady = !(mPack == RATIO - 1 && mCount == DEPTH);
      if (we) checkOutput("wr_ready", {127'b0, bus.wr_ready}, {127'b0, expReady});
      acc    = we & expReady;
      popNow = bus.rd_valid & rr;
      if (popNow) begin
         if (sb.size() == 0) begin
            checkOutput("pop_with_empty_scoreboard", {127'b0, bus.rd_valid}, 128'd0);
         end else begin
            checkOutput("rd_data", bus.rd_data, sb.pop_front());
         end
      end
      @(posedge clk_100);
      #1;
      bus.wr_en    = 1'b0;
      bus.rd_ready = 1'b0;
      if (acc) begin
         mWord[mPack*16 +: 16] = d;
         if (mPack == RATIO - 1) begin
            sb.push_back(mWord);
            mCount++;
            mPack = 0;
         end else begin
            mPack++;
         end
      end else if (we) begin
         mOvf = 1'b1;
      end
      if (popNow) mCount--;
   endtask

   task automatic stepClock();
      @(posedge clk_100);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      load         = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_data  = '0;
      bus.rd_ready = 1'b0;
`ifdef PACK_PAD_EN
      flush_partial = 1'b0;
`endif

      // Reset values.
      #23;
      checkOutput("rst_wcount",   128'(bus.wcount),   128'd0);
      checkOutput("rst_pack_cnt", 128'(bus.pack_cnt), 128'd0);
      checkOutput("rst_rd_valid", 128'(bus.rd_valid), 128'd0);
      checkOutput("rst_wr_ready", 128'(bus.wr_ready), 128'd0);
      checkOutput("rst_overflow", 128'(bus.overflow), 128'd0);
      checkOutput("rst_init_ok",  128'(bus.init_ok),  128'd0);
      checkOutput("rst_rd_data",  bus.rd_data,        128'd0);

      // Busy for exactly 16 cycles after reset release.
      @(posedge clk_100);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         stepClock();
         checkOutput("init_ok_after_reset", 128'(bus.init_ok), (k == 16) ? 128'd1 : 128'd0);
      end
      checkOutput("run_wcount",   128'(bus.wcount),   128'd0);
      checkOutput("run_rd_valid", 128'(bus.rd_valid), 128'd0);

      // First packed word, LSB-first lane order.
      for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b0);
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("first_rd_valid", 128'(bus.rd_valid), 128'd1);
      checkOutput("first_word", bus.rd_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      checkOutput("first_wcount", 128'(bus.wcount), 128'd1);
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("after_pop_wcount",   128'(bus.wcount),   128'd0);
      checkOutput("after_pop_rd_valid", 128'(bus.rd_valid), 128'd0);

      // Fill to DEPTH with a full packer, then one dropped write.
      for (int i = 0; i < 39; i++) applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0);
      checkOutput("full_wcount",   128'(bus.wcount),   128'(mCount));
      checkOutput("full_pack_cnt", 128'(bus.pack_cnt), 128'(mPack));
      checkOutput("full_overflow", 128'(bus.overflow), 128'(mOvf));
      applyStimulus(1'b1, 16'hBEEF, 1'b0);
      checkOutput("drop_overflow", 128'(bus.overflow), 128'(mOvf));
      checkOutput("drop_pack_cnt", 128'(bus.pack_cnt), 128'd7);
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("pop_frees_wcount", 128'(bus.wcount), 128'd3);
      applyStimulus(1'b1, 16'h1027, 1'b0);
      checkOutput("refill_wcount",   128'(bus.wcount),   128'd4);
      checkOutput("refill_pack_cnt", 128'(bus.pack_cnt), 128'd0);

      // Pop and commit on the same edge keep occupancy unchanged.
      applyStimulus(1'b0, 16'h0, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0);
      checkOutput("pre_simul_wcount",   128'(bus.wcount),   128'd3);
      checkOutput("pre_simul_pack_cnt", 128'(bus.pack_cnt), 128'd7);
      applyStimulus(1'b1, 16'h2007, 1'b1);
      checkOutput("simul_wcount",   128'(bus.wcount),   128'(mCount));
      checkOutput("simul_pack_cnt", 128'(bus.pack_cnt), 128'd0);
      for (int n = 0; n < 20; n++) begin
         if (!bus.rd_valid) break;
         applyStimulus(1'b0, 16'h0, 1'b1);
      end
      checkOutput("drain_scoreboard", 128'(sb.size()), 128'd0);
      checkOutput("drain_wcount",     128'(bus.wcount), 128'd0);
      checkOutput("drain_rd_valid",   128'(bus.rd_valid), 128'd0);
      checkOutput("overflow_sticky",  128'(bus.overflow), 128'd1);

      // Mid-frame load, then a second edge five cycles later.
      for (int i = 0; i < 29; i++) applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0);
      checkOutput("midframe_wcount",   128'(bus.wcount),   128'd3);
      checkOutput("midframe_pack_cnt", 128'(bus.pack_cnt), 128'd5);
      load = 1'b1;
      stepClock();
      checkOutput("load_init_ok",  128'(bus.init_ok),  128'd0);
      checkOutput("load_wcount",   128'(bus.wcount),   128'd0);
      checkOutput("load_pack_cnt", 128'(bus.pack_cnt), 128'd0);
      checkOutput("load_overflow", 128'(bus.overflow), 128'd0);
      checkOutput("load_rd_valid", 128'(bus.rd_valid), 128'd0);
      sb.delete();
      mCount = 0;
      mPack  = 0;
      mOvf   = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h5555;
      stepClock();
      load = 1'b0;
      stepClock();
      stepClock();
      stepClock();
      checkOutput("flush_wr_ready", 128'(bus.wr_ready), 128'd0);
      load = 1'b1;
      stepClock();
      load = 1'b0;
      bus.wr_en = 1'b0;
      checkOutput("flush_ignores_wr_overflow", 128'(bus.overflow), 128'd0);
      checkOutput("flush_ignores_wr_pack",     128'(bus.pack_cnt), 128'd0);
      for (int k = 1; k <= 16; k++) begin
         stepClock();
         checkOutput("init_ok_after_reload", 128'(bus.init_ok), (k == 16) ? 128'd1 : 128'd0);
      end

`ifdef PACK_PAD_EN
      // Partial word padded with PAD_VALUE.
      applyStimulus(1'b1, 16'h000A, 1'b0);
      applyStimulus(1'b1, 16'h000B, 1'b0);
      flush_partial = 1'b1;
      stepClock();
      flush_partial = 1'b0;
      for (int n = 0; n < 10; n++) begin
         if (bus.rd_valid) break;
         stepClock();
      end
      checkOutput("pad_rd_valid", 128'(bus.rd_valid), 128'd1);
      checkOutput("pad_word", bus.rd_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_000B_000A);
      checkOutput("pad_pack_cnt", 128'(bus.pack_cnt), 128'd0);
      checkOutput("pad_wcount",   128'(bus.wcount),   128'd1);
      bus.rd_ready = 1'b1;
      stepClock();
      bus.rd_ready = 1'b0;
      checkOutput("pad_pop_wcount", 128'(bus.wcount), 128'd0);
      mPack = 0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
